ks_pipe_adder: RTL and testbench

Pipelined, width-parametrised Kogge-Stone adder/subtractor with a valid/ready handshake. It computes propagate/generate terms, runs the log2(WIDTH) prefix network in register-separated groups of levels, and forms sum and carry-out. It is the next generation of the team's 32-bit combinational Kogge-Stone sum stage, for datapaths that need arbitrary width, a subtract mode and timing-closure pipelining.

---
 rtl/ks_pipe_adder_pkg.sv | 22 ++
 rtl/ks_pipe_adder_prefix_level.sv | 21 ++
 rtl/ks_pipe_adder.sv | 122 ++++++++++++
 tb/tb_ks_pipe_adder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pipe_adder_pkg.sv
// Sizing helpers shared by the pipelined Kogge-Stone adder and its prefix levels.
package ks_pkg;

    // Number of prefix levels: ceil(log2(width)).
    function automatic int unsigned ks_levels(input int unsigned width);
        int unsigned lv;
        lv = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(width)) begin
                lv = i + 1;
            end
        end
        return lv;
    endfunction

    // Number of register-separated groups of prefix levels.
    function automatic int unsigned ks_ngrp(input int unsigned levels,
                                            input int unsigned per_stage);
        return (levels + per_stage - 1) / per_stage;
    endfunction

endpackage

// File: rtl/ks_pipe_adder_prefix_level.sv
// One combinational Kogge-Stone prefix level combining each bit with the bit DIST below it.
module ks_prefix_level #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIST  = 1
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] p_lvl,
    output logic [WIDTH-1:0] g_lvl
);

    always_comb begin
        p_lvl = p;
        g_lvl = g;
        for (int unsigned i = DIST; i < WIDTH; i++) begin
            g_lvl[i] = g[i] | (p[i] & g[i - DIST]);
            p_lvl[i] = p[i] & p[i - DIST];
        end
    end

endmodule

// File: rtl/ks_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor with a global-stall valid/ready handshake.
// Define KS_PIPE_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module ks_pipe_adder
    import ks_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned STAGE_LEVELS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef KS_PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned LEVELS = ks_levels(WIDTH);
    localparam int unsigned NGRP   = ks_ngrp(LEVELS, STAGE_LEVELS);

    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
    } pg_t;

    typedef struct packed {
        logic             valid;
        logic             c0;
        logic [WIDTH-1:0] praw;
        pg_t              pg;
    } stage_t;

    stage_t           stage_p;
    stage_t           grp_d [1:NGRP];
    stage_t           grp_q [NGRP+1];
    logic [WIDTH-1:0] lvl_p [LEVELS];
    logic [WIDTH-1:0] lvl_g [LEVELS];
    logic [WIDTH-1:0] nxt_p [LEVELS];
    logic [WIDTH-1:0] nxt_g [LEVELS];
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Carry-in is folded into bit 0 generate so the prefix network needs no extra column.
    always_comb begin
        b_eff           = sub ? ~b : b;
        c0              = sub | cin;
        stage_p         = '0;
        stage_p.valid   = in_valid;
        stage_p.c0      = c0;
        stage_p.praw    = a ^ b_eff;
        stage_p.pg.p    = a ^ b_eff;
        stage_p.pg.g    = a & b_eff;
        stage_p.pg.g[0] = (a[0] & b_eff[0]) | ((a[0] ^ b_eff[0]) & c0);
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        if (k % STAGE_LEVELS == 0) begin : g_reg_src
            assign lvl_p[k] = grp_q[k / STAGE_LEVELS].pg.p;
            assign lvl_g[k] = grp_q[k / STAGE_LEVELS].pg.g;
        end else begin : g_comb_src
            assign lvl_p[k] = nxt_p[k-1];
            assign lvl_g[k] = nxt_g[k-1];
        end

        ks_prefix_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_level (
            .p     (lvl_p[k]),
            .g     (lvl_g[k]),
            .p_lvl (nxt_p[k]),
            .g_lvl (nxt_g[k])
        );
    end

    // The last group may hold fewer than STAGE_LEVELS levels.
    for (genvar gi = 1; gi <= NGRP; gi++) begin : g_group
        localparam int unsigned LAST = (gi * STAGE_LEVELS < LEVELS) ?
                                       gi * STAGE_LEVELS - 1 : LEVELS - 1;
        assign grp_d[gi] = {grp_q[gi-1].valid, grp_q[gi-1].c0, grp_q[gi-1].praw,
                            nxt_p[LAST], nxt_g[LAST]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i <= NGRP; i++) begin
                grp_q[i] <= '0;
            end
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef KS_PIPE_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (adv) begin
            grp_q[0] <= stage_p;
            for (int unsigned i = 1; i <= NGRP; i++) begin
                grp_q[i] <= grp_d[i];
            end
            out_valid <= grp_q[NGRP].valid;
            sum       <= grp_q[NGRP].praw ^ {grp_q[NGRP].pg.g[WIDTH-2:0], grp_q[NGRP].c0};
            cout      <= grp_q[NGRP].pg.g[WIDTH-1];
`ifdef KS_PIPE_ADDER_OVF_EN
            ovf       <= grp_q[NGRP].pg.g[WIDTH-1] ^ grp_q[NGRP].pg.g[WIDTH-2];
`endif
        end
    end

endmodule

// File: tb/tb_ks_pipe_adder.sv
// Bench for ks_pipe_adder: directed cases plus randomized traffic against an arithmetic reference.
`timescale 1ns/1ps
module tb_ks_pipe_adder;

    localparam int W   = 32;
    localparam int SL  = 2;
    localparam int LAT = ($clog2(W) + SL - 1) / SL + 2;

    typedef struct {
        bit         v;
        logic [W-1:0] s;
        bit         c;
        bit         o;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
    logic [W-1:0] a, b, sum;
    logic         in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8;
    logic [7:0]   a8, b8, sum8;
`ifdef KS_PIPE_ADDER_OVF_EN
    logic         ovf, ovf8;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ks_pipe_adder #(.WIDTH(W), .STAGE_LEVELS(SL)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef KS_PIPE_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    ks_pipe_adder #(.WIDTH(8), .STAGE_LEVELS(3)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .cout(cout8)
`ifdef KS_PIPE_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain wide addition; overflow from operand/result sign rule.
    function automatic res_t golden(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic ci, input logic sb, input bit v);
        res_t r;
        logic [W-1:0] ye;
        logic [W:0]   tot;
        ye  = sb ? ~y : y;
        tot = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
        r.v = v;
        r.s = tot[W-1:0];
        r.c = tot[W];
        r.o = (x[W-1] == ye[W-1]) && (tot[W-1] != x[W-1]);
        return r;
    endfunction

    // Fixed-latency delay line; the whole line freezes while the output is held.
    res_t mpipe [LAT];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) mpipe[i].v <= 1'b0;
        end else if (!mpipe[LAT-1].v || out_ready) begin
            for (int i = LAT - 1; i > 0; i--) mpipe[i] <= mpipe[i-1];
            mpipe[0] <= golden(a, b, cin, sub, in_valid);
        end
    end

    always @(negedge clk) begin
        check("out_valid", out_valid, mpipe[LAT-1].v);
        check("in_ready", in_ready, !mpipe[LAT-1].v || out_ready);
        if (mpipe[LAT-1].v) begin
            check("sum", sum, mpipe[LAT-1].s);
            check("cout", cout, mpipe[LAT-1].c);
`ifdef KS_PIPE_ADDER_OVF_EN
            check("ovf", ovf, mpipe[LAT-1].o);
`endif
        end
    end

    logic [W-1:0] rcv [$];
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) rcv.push_back(sum);
    end

    task automatic drive(input bit v, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic sb);
        @(posedge clk);
        #2;
        in_valid = v; a = x; b = y; cin = ci; sub = sb;
    endtask

    task automatic run_one(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic ci, input logic sb, output int cnt);
        drive(1'b1, x, y, ci, sb);
        @(posedge clk);
        cnt = 1;
        #2;
        in_valid = 1'b0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk);
            cnt++;
            #2;
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        res_t r;
        int   cnt;
        int   seen;
        in_valid = 0; a = '0; b = '0; cin = 0; sub = 0; out_ready = 1;
        in_valid8 = 0; a8 = '0; b8 = '0; cin8 = 0; sub8 = 0; out_ready8 = 1;

        #1 rst = 1'b1;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_in_ready", in_ready, 1);
`ifdef KS_PIPE_ADDER_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        r = golden(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
        check("pin_wrap", {r.c, r.s}, 33'h1_0000_0000);
        r = golden(32'd5, 32'd7, 1'b1, 1'b1, 1'b1);
        check("pin_sub", {r.c, r.s}, 33'h0_FFFF_FFFE);
        r = golden(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
        check("pin_ovf", {r.o, r.c, r.s}, 34'h0_8000_0000 | 34'h2_0000_0000);

        run_one(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, cnt);
        check("lat_add", cnt, 5);
        check("wrap_sum", sum, 32'h0);
        check("wrap_cout", cout, 1);

        run_one(32'd5, 32'd7, 1'b1, 1'b1, cnt);
        check("lat_sub", cnt, 5);
        check("sub_sum", sum, 32'hFFFF_FFFE);
        check("sub_cout", cout, 0);

`ifdef KS_PIPE_ADDER_OVF_EN
        run_one(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, cnt);
        check("ovf_pos_sum", sum, 32'h8000_0000);
        check("ovf_pos_ovf", ovf, 1);
        check("ovf_pos_cout", cout, 0);
        run_one(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, cnt);
        check("ovf_neg_sum", sum, 32'h0);
        check("ovf_neg_ovf", ovf, 1);
        check("ovf_neg_cout", cout, 1);
`endif

        // Four back-to-back beats, output held for three cycles after the first result.
        repeat (3) @(posedge clk);
        rcv.delete();
        for (int i = 1; i <= 4; i++) drive(1'b1, W'(i), W'(i), 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk);
            #2;
            cnt++;
        end
        check("stall_first_valid", out_valid, 1);
        out_ready = 1'b0;
        repeat (3) begin
            #1 check("stall_in_ready", in_ready, 0);
            @(posedge clk);
            #2;
        end
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        check("stall_count", rcv.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < rcv.size()) check("stall_order", rcv[i], 64'(2 * (i + 1)));
        end

        // Reset while beats are in flight and one result is presented.
        for (int i = 0; i < 5; i++) drive(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0);
        @(posedge clk);
        #2 in_valid = 1'b0;
        check("rst_pre_valid", out_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_sum", sum, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #2;
            if (out_valid) seen++;
        end
        check("rst_no_stale", seen, 0);
        check("rst_post_ready", in_ready, 1);

        repeat (400) begin
            @(posedge clk);
            #2;
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = pick();
            b         = pick();
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk);
        #2;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (LAT + 3) @(posedge clk);

        // Narrow instance: 8 bits, one group of three levels.
        @(posedge clk);
        #2;
        in_valid8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1; sub8 = 1'b0;
        @(posedge clk);
        cnt = 1;
        #2 in_valid8 = 1'b0;
        while (!out_valid8 && cnt < 20) begin
            @(posedge clk);
            cnt++;
            #2;
        end
        check("w8_lat", cnt, 3);
        check("w8_sum", sum8, 8'h01);
        check("w8_cout", cout8, 1);

        @(posedge clk);
        #2;
        in_valid8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; sub8 = 1'b1;
        @(posedge clk);
        cnt = 1;
        #2 in_valid8 = 1'b0;
        while (!out_valid8 && cnt < 20) begin
            @(posedge clk);
            cnt++;
            #2;
        end
        check("w8_sub_sum", sum8, 8'hF0);
        check("w8_sub_cout", cout8, 0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
